led_pwm_fader: RTL and testbench

LED_PWM_FADER -- requirements
Module: led_pwm_fader

---
 rtl/led_pwm_fader.sv | 135 +++++++++++++
 tb/tb_led_pwm_fader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// Four-channel active-low LED PWM driver with optional linear brightness fading (macro LED_PWM_FADER_FADE_EN).
// Latency: inputs registered once; led_out/busy/pwm_sync are registered; duty updates at PWM period boundaries.
// Backpressure: none; free-running counters, inputs sampled every cycle.
module led_pwm_fader #(
  parameter int unsigned PWM_BITS         = 8,
  parameter logic [31:0] FADE_STEP_CYCLES = 32'd1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          led_in,
  input  logic [PWM_BITS-1:0] duty_max,
  output logic [3:0]          led_out,
  output logic                busy,
  output logic                pwm_sync
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [3:0]          led_in_q;
  logic [PWM_BITS-1:0] duty_max_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] target    [4];
  logic [PWM_BITS-1:0] level     [4];
  logic [PWM_BITS-1:0] level_nxt [4];
  logic [PWM_BITS-1:0] shadow    [4];
  logic                period_end;

  // A zero step period would never produce a step tick.
  if (FADE_STEP_CYCLES == 32'd0) begin : g_bad_step
    $error("FADE_STEP_CYCLES must be >= 1");
  end

  assign period_end = (pwm_cnt == PWM_MAX);

  // Requested-on channels aim for the brightness ceiling, others for dark.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      target[i] = led_in_q[i] ? '0 : duty_max_q;
    end
  end

  // Input sampling, PWM counter, sync pulse, period-aligned shadow and LED drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_in_q   <= 4'b1111;
      duty_max_q <= '0;
      pwm_cnt    <= '0;
      pwm_sync   <= 1'b0;
      led_out    <= 4'b1111;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      led_in_q   <= led_in;
      duty_max_q <= duty_max;
      pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
      pwm_sync   <= (pwm_cnt == '0);
      for (int i = 0; i < 4; i++) begin
        // Shadow takes the level as it stands before any same-cycle step.
        if (period_end) begin
          shadow[i] <= level[i];
        end
        led_out[i] <= ~(pwm_cnt < shadow[i]);
      end
    end
  end

`ifdef LED_PWM_FADER_FADE_EN
  localparam int STEP_W = (FADE_STEP_CYCLES > 32'd1) ? $clog2(FADE_STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_CYCLES - 32'd1);

  logic [STEP_W-1:0] step_cnt;
  logic              step_tick;
  logic [3:0]        differ;

  assign step_tick = (step_cnt == STEP_LAST);

  // Step-rate divider; wraps in the tick cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_tick ? '0 : step_cnt + STEP_W'(1);
    end
  end

  // Move each level one count toward its target per tick; targets are in range so no wrap.
  always_comb begin
    differ = '0;
    for (int i = 0; i < 4; i++) begin
      level_nxt[i] = level[i];
      differ[i]    = (level[i] != target[i]);
      if (step_tick) begin
        if (level[i] < target[i]) begin
          level_nxt[i] = level[i] + PWM_BITS'(1);
        end else if (level[i] > target[i]) begin
          level_nxt[i] = level[i] - PWM_BITS'(1);
        end
      end
    end
  end

  // Busy while any channel is still ramping.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= |differ;
    end
  end
`else
  // Without fading, levels follow targets directly.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      level_nxt[i] = target[i];
    end
  end

  assign busy = 1'b0;
`endif

  // Brightness level registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        level[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        level[i] <= level_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader with PWM_BITS=4, FADE_STEP_CYCLES=4.
// Reference model indexes time by cycles since reset release; period and step phase come from modulo arithmetic.
// Directed scenarios followed by randomized input changes and resets.
module tb_led_pwm_fader;

  localparam int PB    = 4;
  localparam int FSC   = 4;
  localparam int PER   = 1 << PB;
  localparam int LVMAX = PER - 1;
`ifdef LED_PWM_FADER_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    led_in;
  logic [PB-1:0] duty_max;
  logic [3:0]    led_out;
  logic          busy;
  logic          pwm_sync;

  led_pwm_fader #(.PWM_BITS(PB), .FADE_STEP_CYCLES(32'(FSC))) dut (
    .clk      (clk),
    .reset    (reset),
    .led_in   (led_in),
    .duty_max (duty_max),
    .led_out  (led_out),
    .busy     (busy),
    .pwm_sync (pwm_sync)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: edges since release, sampled inputs, levels, shadows, expected outputs.
  int         m_k = 0;
  logic [3:0] m_lin_q = 4'b1111;
  int         m_dm_q = 0;
  int         m_level [4];
  int         m_shadow [4];
  logic [3:0] m_led = 4'b1111;
  logic       m_busy = 1'b0;
  logic       m_sync = 1'b0;
  int         low_cnt [4];

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model across the edge, compare on the falling edge.
  task automatic cyc(input logic r, input logic [3:0] li, input int dm);
    int         pre;
    bit         tick;
    int         tgt;
    int         nl [4];
    int         ns [4];
    logic [3:0] nled;
    logic       nbusy;
    reset    = r;
    led_in   = li;
    duty_max = PB'(dm);
    @(posedge clk);
    if (r) begin
      m_k = 0; m_lin_q = 4'b1111; m_dm_q = 0;
      for (int i = 0; i < 4; i++) begin m_level[i] = 0; m_shadow[i] = 0; end
      m_led = 4'b1111; m_busy = 1'b0; m_sync = 1'b0;
    end else begin
      pre   = m_k % PER;
      tick  = ((m_k % FSC) == FSC - 1);
      nbusy = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tgt     = m_lin_q[i] ? 0 : m_dm_q;
        ns[i]   = (pre == LVMAX) ? m_level[i] : m_shadow[i];
        nled[i] = !(pre < m_shadow[i]);
        if (FADE) begin
          nl[i] = m_level[i];
          if (tick && m_level[i] < tgt) nl[i] = m_level[i] + 1;
          if (tick && m_level[i] > tgt) nl[i] = m_level[i] - 1;
          if (m_level[i] != tgt) nbusy = 1'b1;
        end else begin
          nl[i] = tgt;
        end
        if (nl[i] < 0 || nl[i] > LVMAX) nl[i] = -1;
      end
      m_sync = (pre == 0);
      m_k++;
      m_lin_q = li;
      m_dm_q  = dm;
      for (int i = 0; i < 4; i++) begin m_level[i] = nl[i]; m_shadow[i] = ns[i]; end
      m_led  = nled;
      m_busy = nbusy;
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_bit($sformatf("led_out[%0d]", i), led_out[i], m_led[i]);
      if (led_out[i] === 1'b0) low_cnt[i]++;
    end
    check_bit("busy", busy, m_busy);
    check_bit("pwm_sync", pwm_sync, m_sync);
  endtask

  task automatic run(input int n, input logic [3:0] li, input int dm);
    for (int c = 0; c < n; c++) cyc(1'b0, li, dm);
  endtask

  // Hold inputs one full period and compare per-channel on-time against fixed expectations.
  task automatic measure(input string tag, input logic [3:0] li, input int dm,
                         input int e0, input int e1, input int e2, input int e3);
    int exp_low [4];
    exp_low[0] = e0; exp_low[1] = e1; exp_low[2] = e2; exp_low[3] = e3;
    for (int i = 0; i < 4; i++) low_cnt[i] = 0;
    run(PER, li, dm);
    for (int i = 0; i < 4; i++) check_int($sformatf("%s_low[%0d]", tag, i), low_cnt[i], exp_low[i]);
    check_bit({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; led_in = 4'b1111; duty_max = '0;
    // Reset held three cycles: outputs idle, no sync pulse.
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 4'b1111, 0);
      check_bit("rst_led_all_off", &led_out, 1'b1);
      check_bit("rst_sync_low", pwm_sync, 1'b0);
    end
    // First cycle after release carries the first sync pulse.
    cyc(1'b0, 4'b1110, 8);
    check_bit("first_sync", pwm_sync, 1'b1);

    // Channel 0 ramps to 8 then settles at half duty.
    run(70, 4'b1110, 8);
    measure("half", 4'b1110, 8, 8, 0, 0, 0);

    // Release channel 0: ramp down to dark.
    run(70, 4'b1111, 8);
    measure("dark", 4'b1111, 8, 0, 0, 0, 0);

    // All channels at maximum, then ceiling dropped to 0.
    run(100, 4'b0000, 15);
    measure("full", 4'b0000, 15, 15, 15, 15, 15);
    run(100, 4'b0000, 0);
    measure("zero", 4'b0000, 0, 0, 0, 0, 0);

    // Reset mid-ramp, then ramp again from zero.
    run(22, 4'b1110, 8);
    cyc(1'b1, 4'b1110, 8);
    check_bit("midramp_rst_off", &led_out, 1'b1);
    run(70, 4'b1110, 8);
    measure("reramp", 4'b1110, 8, 8, 0, 0, 0);

    // Redirect mid-ramp by changing the ceiling.
    run(10, 4'b1010, 12);
    run(30, 4'b1010, 3);
    run(30, 4'b0101, 9);

    // Randomized input changes with occasional resets.
    begin
      logic [3:0] li;
      int         dm;
      li = 4'b1111; dm = 0;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(7, 0) == 0) begin
          li = 4'($urandom);
          dm = $urandom_range(LVMAX, 0);
        end
        cyc(($urandom_range(79, 0) == 0), li, dm);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
